// File: rtl/ap_ctrl_perf_monitor_if.sv
// Handshake and read-port bundle for ap_ctrl_perf_monitor.
// master: the side that drives the monitored handshakes and issues reads.
// slave : the monitor itself.
interface ap_ctrl_perf_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] ch_start;
    logic [NUM_CH-1:0] ch_ready;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_continue;
    logic [NUM_CH-1:0] ch_iter;
    logic              rd_req;
    logic [CH_W-1:0]   rd_ch;
    logic [2:0]        rd_sel;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] ch_busy;
    logic              any_ovf;

    modport master (
        output ch_start, ch_ready, ch_done, ch_continue, ch_iter,
        output rd_req, rd_ch, rd_sel,
        input  rd_valid, rd_data, ch_busy, any_ovf
    );

    modport slave (
        input  ch_start, ch_ready, ch_done, ch_continue, ch_iter,
        input  rd_req, rd_ch, rd_sel,
        output rd_valid, rd_data, ch_busy, any_ovf
    );
endinterface

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl_hs / ap_ctrl_chain performance monitor.
// Each channel tracks start/done/continue with a small FSM and accumulates
// saturating transaction, latency, busy-cycle and iteration counters.
// A registered read port exposes every counter one cycle after a request.
// Optional feature: define APMON_MINMAX_EN to keep per-channel min/max latency.
module ap_ctrl_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  finish,
    ap_ctrl_perf_monitor_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DWAIT = 2'd2
    } state_t;

    // Saturating increment: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) sat_inc = v + CNT_ONE;
        else                      sat_inc = v;
    endfunction

    // True when this increment lands the counter on (or keeps it at) all-ones.
    function automatic logic hit_max(input logic [CNT_W-1:0] v, input logic en);
        hit_max = en && (v >= (CNT_MAX - CNT_ONE));
    endfunction

    state_t            state_r     [NUM_CH];
    state_t            state_nxt_s [NUM_CH];
    logic [CNT_W-1:0]  lat_r       [NUM_CH];
    logic [CNT_W-1:0]  lat_nxt_s   [NUM_CH];
    logic [CNT_W-1:0]  start_cnt_r [NUM_CH];
    logic [CNT_W-1:0]  done_cnt_r  [NUM_CH];
    logic [CNT_W-1:0]  busy_cyc_r  [NUM_CH];
    logic [CNT_W-1:0]  last_lat_r  [NUM_CH];
    logic [CNT_W-1:0]  iter_cnt_r  [NUM_CH];
`ifdef APMON_MINMAX_EN
    logic [CNT_W-1:0]  min_lat_r   [NUM_CH];
    logic [CNT_W-1:0]  max_lat_r   [NUM_CH];
`endif
    logic [CNT_W-1:0]  ch_val_s    [NUM_CH];
    logic [NUM_CH-1:0] start_hit_s;
    logic [NUM_CH-1:0] cmpl_s;
    logic [NUM_CH-1:0] busy_inc_s;
    logic [NUM_CH-1:0] lat_inc_s;
    logic [NUM_CH-1:0] ovf_r;
    logic [NUM_CH-1:0] ovf_nxt_s;
    logic [NUM_CH-1:0] ch_busy_r;
    logic              any_ovf_r;
    logic              rd_valid_r;
    logic [CNT_W-1:0]  rd_data_r;
    logic [CNT_W-1:0]  rd_mux_s;

    assign start_hit_s = bus.ch_start & bus.ch_ready;

    // Per-channel FSM next state, latency tracking and completion detect.
    always_comb begin
        cmpl_s     = {NUM_CH{1'b0}};
        busy_inc_s = {NUM_CH{1'b0}};
        lat_inc_s  = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt_s[i] = state_r[i];
            lat_nxt_s[i]   = lat_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (bus.ch_start[i]) begin
                        lat_nxt_s[i] = CNT_ONE;
                        if (bus.ch_done[i] && bus.ch_continue[i]) begin
                            cmpl_s[i]      = 1'b1;
                            state_nxt_s[i] = ST_IDLE;
                        end else if (bus.ch_done[i]) begin
                            state_nxt_s[i] = ST_DWAIT;
                        end else begin
                            state_nxt_s[i] = ST_BUSY;
                        end
                    end else begin
                        state_nxt_s[i] = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    busy_inc_s[i] = 1'b1;
                    lat_inc_s[i]  = 1'b1;
                    lat_nxt_s[i]  = sat_inc(lat_r[i], 1'b1);
                    if (bus.ch_done[i] && bus.ch_continue[i]) begin
                        cmpl_s[i]      = 1'b1;
                        state_nxt_s[i] = ST_IDLE;
                    end else if (bus.ch_done[i]) begin
                        state_nxt_s[i] = ST_DWAIT;
                    end else begin
                        state_nxt_s[i] = ST_BUSY;
                    end
                end
                ST_DWAIT: begin
                    busy_inc_s[i] = 1'b1;
                    if (bus.ch_continue[i]) begin
                        cmpl_s[i]      = 1'b1;
                        state_nxt_s[i] = ST_IDLE;
                    end else begin
                        state_nxt_s[i] = ST_DWAIT;
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: set when any counter of the channel reaches all-ones.
    always_comb begin
        ovf_nxt_s = ovf_r;
        for (int i = 0; i < NUM_CH; i++) begin
            ovf_nxt_s[i] = ovf_r[i]
                         | hit_max(start_cnt_r[i], start_hit_s[i])
                         | hit_max(done_cnt_r[i],  cmpl_s[i])
                         | hit_max(busy_cyc_r[i],  busy_inc_s[i])
                         | hit_max(iter_cnt_r[i],  bus.ch_iter[i])
                         | hit_max(lat_r[i],       lat_inc_s[i]);
        end
    end

    // State and counter registers; everything holds while finish is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i]     <= ST_IDLE;
                lat_r[i]       <= CNT_ZERO;
                start_cnt_r[i] <= CNT_ZERO;
                done_cnt_r[i]  <= CNT_ZERO;
                busy_cyc_r[i]  <= CNT_ZERO;
                last_lat_r[i]  <= CNT_ZERO;
                iter_cnt_r[i]  <= CNT_ZERO;
`ifdef APMON_MINMAX_EN
                min_lat_r[i]   <= CNT_MAX;
                max_lat_r[i]   <= CNT_ZERO;
`endif
            end
            ovf_r     <= {NUM_CH{1'b0}};
            ch_busy_r <= {NUM_CH{1'b0}};
            any_ovf_r <= 1'b0;
        end else if (!finish) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i]     <= state_nxt_s[i];
                lat_r[i]       <= lat_nxt_s[i];
                start_cnt_r[i] <= sat_inc(start_cnt_r[i], start_hit_s[i]);
                done_cnt_r[i]  <= sat_inc(done_cnt_r[i], cmpl_s[i]);
                busy_cyc_r[i]  <= sat_inc(busy_cyc_r[i], busy_inc_s[i]);
                iter_cnt_r[i]  <= sat_inc(iter_cnt_r[i], bus.ch_iter[i]);
                ch_busy_r[i]   <= (state_nxt_s[i] != ST_IDLE);
                if (cmpl_s[i]) begin
                    // lat_nxt_s already includes the completing cycle
                    last_lat_r[i] <= lat_nxt_s[i];
`ifdef APMON_MINMAX_EN
                    if (lat_nxt_s[i] < min_lat_r[i]) min_lat_r[i] <= lat_nxt_s[i];
                    if (lat_nxt_s[i] > max_lat_r[i]) max_lat_r[i] <= lat_nxt_s[i];
`endif
                end
            end
            ovf_r     <= ovf_nxt_s;
            any_ovf_r <= |ovf_nxt_s;
        end
    end

    // Per-channel view of the selected counter (pre-update values).
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            case (bus.rd_sel)
                3'd0:    ch_val_s[i] = start_cnt_r[i];
                3'd1:    ch_val_s[i] = done_cnt_r[i];
                3'd2:    ch_val_s[i] = busy_cyc_r[i];
                3'd3:    ch_val_s[i] = last_lat_r[i];
                3'd4:    ch_val_s[i] = iter_cnt_r[i];
`ifdef APMON_MINMAX_EN
                3'd5:    ch_val_s[i] = min_lat_r[i];
                3'd6:    ch_val_s[i] = max_lat_r[i];
`else
                3'd5:    ch_val_s[i] = CNT_ZERO;
                3'd6:    ch_val_s[i] = CNT_ZERO;
`endif
                3'd7:    ch_val_s[i] = {{(CNT_W-3){1'b0}}, ovf_r[i], state_r[i]};
                default: ch_val_s[i] = CNT_ZERO;
            endcase
        end
    end

    // Channel select as an AND-OR mux; an out-of-range rd_ch matches nothing and yields 0.
    always_comb begin
        rd_mux_s = CNT_ZERO;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_mux_s = rd_mux_s | (ch_val_s[i] & {CNT_W{bus.rd_ch == CH_W'(i)}});
        end
    end

    // Registered read port; data holds when no request is made.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= CNT_ZERO;
        end else begin
            rd_valid_r <= bus.rd_req;
            if (bus.rd_req) rd_data_r <= rd_mux_s;
        end
    end

    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.ch_busy  = ch_busy_r;
    assign bus.any_ovf  = any_ovf_r;
endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Self-checking bench for ap_ctrl_perf_monitor (NUM_CH=5, CNT_W=8).
// Every cycle is compared against a procedural model of the channel rules;
// a table of hand-derived reads checks the directed scenarios.
module tb_ap_ctrl_perf_monitor;
    localparam int NCH  = 5;
    localparam int CW   = 8;
    localparam int MAXV = 255;
`ifdef APMON_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic finish;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    ap_ctrl_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clock  (clock),
        .reset  (reset),
        .finish (finish),
        .bus    (bus)
    );

    typedef struct {
        int phase;
        int ch;
        int sel;
        int exp;
    } rd_vec_t;

    rd_vec_t tbl[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: state 0 idle, 1 running, 2 waiting for continue
    int m_st[NCH], m_lat[NCH], m_start[NCH], m_done[NCH], m_busy[NCH];
    int m_last[NCH], m_iter[NCH], m_min[NCH], m_max[NCH];
    bit m_ovf[NCH];
    int exp_valid = 0;
    int exp_data  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int bump(input int v, input int c);
        if (v + 1 >= MAXV) m_ovf[c] = 1'b1;
        return (v + 1 > MAXV) ? MAXV : v + 1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_st[c] = 0; m_lat[c] = 0; m_start[c] = 0; m_done[c] = 0; m_busy[c] = 0;
            m_last[c] = 0; m_iter[c] = 0; m_min[c] = MAXV; m_max[c] = 0; m_ovf[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit s, r, d, k, fin;
            s = bus.ch_start[c]; r = bus.ch_ready[c];
            d = bus.ch_done[c];  k = bus.ch_continue[c];
            fin = 1'b0;
            if (s && r) m_start[c] = bump(m_start[c], c);
            if (bus.ch_iter[c]) m_iter[c] = bump(m_iter[c], c);
            if (m_st[c] == 0) begin
                if (s) begin
                    m_lat[c] = 1;
                    if (d && k) fin = 1'b1;
                    else        m_st[c] = d ? 2 : 1;
                end
            end else if (m_st[c] == 1) begin
                m_busy[c] = bump(m_busy[c], c);
                m_lat[c]  = bump(m_lat[c], c);
                if (d && k)  fin = 1'b1;
                else if (d)  m_st[c] = 2;
            end else begin
                m_busy[c] = bump(m_busy[c], c);
                if (k) fin = 1'b1;
            end
            if (fin) begin
                m_done[c] = bump(m_done[c], c);
                m_last[c] = m_lat[c];
                if (m_lat[c] < m_min[c]) m_min[c] = m_lat[c];
                if (m_lat[c] > m_max[c]) m_max[c] = m_lat[c];
                m_st[c] = 0;
            end
        end
    endtask

    function automatic int model_read(input int ch, input int sel);
        if (ch >= NCH) return 0;
        case (sel)
            0:       return m_start[ch];
            1:       return m_done[ch];
            2:       return m_busy[ch];
            3:       return m_last[ch];
            4:       return m_iter[ch];
            5:       return MM ? m_min[ch] : 0;
            6:       return MM ? m_max[ch] : 0;
            default: return (m_ovf[ch] ? 4 : 0) + m_st[ch];
        endcase
    endfunction

    // One clock: predict from pre-edge inputs, advance, then compare all outputs.
    task automatic tick();
        logic [NCH-1:0] exp_busy;
        bit exp_ovf;
        if (reset) begin
            exp_valid = 0;
            exp_data  = 0;
            model_reset();
        end else begin
            exp_valid = int'(bus.rd_req);
            if (bus.rd_req) exp_data = model_read(int'(bus.rd_ch), int'(bus.rd_sel));
            if (!finish) model_step();
        end
        @(posedge clock);
        #1;
        exp_ovf = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            exp_busy[c] = (m_st[c] != 0);
            exp_ovf     = exp_ovf | m_ovf[c];
        end
        chk("rd_valid", longint'(bus.rd_valid), longint'(exp_valid));
        chk("rd_data",  longint'(bus.rd_data),  longint'(exp_data));
        chk("ch_busy",  longint'(bus.ch_busy),  longint'(exp_busy));
        chk("any_ovf",  longint'(bus.any_ovf),  longint'(exp_ovf));
    endtask

    task automatic clear_inputs();
        bus.ch_start = '0; bus.ch_ready = '0; bus.ch_done = '0;
        bus.ch_continue = '0; bus.ch_iter = '0;
        bus.rd_req = 1'b0; bus.rd_ch = 3'd0; bus.rd_sel = 3'd0;
    endtask

    task automatic rand_inputs();
        for (int c = 0; c < NCH; c++) begin
            bus.ch_start[c]    = ($urandom_range(3) == 0);
            bus.ch_ready[c]    = 1'($urandom_range(1));
            bus.ch_done[c]     = ($urandom_range(4) == 0);
            bus.ch_continue[c] = 1'($urandom_range(1));
            bus.ch_iter[c]     = ($urandom_range(2) == 0);
        end
        bus.rd_req = 1'($urandom_range(1));
        bus.rd_ch  = 3'($urandom_range(7));
        bus.rd_sel = 3'($urandom_range(7));
    endtask

    task automatic check_read(input int ch, input int sel, input int exp, input string name);
        bus.rd_req = 1'b1;
        bus.rd_ch  = 3'(ch);
        bus.rd_sel = 3'(sel);
        tick();
        chk({name, "_valid"}, longint'(bus.rd_valid), 64'sd1);
        chk(name, longint'(bus.rd_data), longint'(exp));
        bus.rd_req = 1'b0;
    endtask

    task automatic run_table(input int phase);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].phase == phase)
                check_read(tbl[i].ch, tbl[i].sel, tbl[i].exp,
                           $sformatf("tbl%0d_ch%0d_sel%0d", i, tbl[i].ch, tbl[i].sel));
        end
    endtask

    initial begin
        // phase 1: single ch0 transaction, latency 10
        tbl.push_back('{1, 0, 0, 1});  tbl.push_back('{1, 0, 1, 1});
        tbl.push_back('{1, 0, 2, 9});  tbl.push_back('{1, 0, 3, 10});
        tbl.push_back('{1, 0, 7, 0});  tbl.push_back('{1, 1, 0, 0});
        tbl.push_back('{1, 0, 5, MM ? 10 : 0}); tbl.push_back('{1, 0, 6, MM ? 10 : 0});
        // phase 2: ch1 with a three-cycle continue stall
        tbl.push_back('{2, 1, 0, 1});  tbl.push_back('{2, 1, 1, 1});
        tbl.push_back('{2, 1, 2, 7});  tbl.push_back('{2, 1, 3, 5});
        tbl.push_back('{2, 1, 7, 0});
        tbl.push_back('{2, 1, 5, MM ? 5 : 0});  tbl.push_back('{2, 1, 6, MM ? 5 : 0});
        // phase 3: ch2 one-cycle transaction plus 100 iterations
        tbl.push_back('{3, 2, 3, 1});  tbl.push_back('{3, 2, 4, 100});
        tbl.push_back('{3, 2, 1, 1});  tbl.push_back('{3, 2, 2, 0});
        tbl.push_back('{3, 2, 5, MM ? 1 : 0});  tbl.push_back('{3, 2, 6, MM ? 1 : 0});
        // phase 4: ch3 iteration counter saturates
        tbl.push_back('{4, 3, 4, 255}); tbl.push_back('{4, 3, 7, 4});
        tbl.push_back('{4, 3, 0, 0});   tbl.push_back('{4, 2, 4, 100});
        tbl.push_back('{4, 0, 7, 0});   tbl.push_back('{4, 2, 7, 0});
        // phase 5: frozen by finish during a ch0 transaction; out-of-range channels
        tbl.push_back('{5, 0, 0, 2});  tbl.push_back('{5, 0, 1, 1});
        tbl.push_back('{5, 0, 2, 12}); tbl.push_back('{5, 0, 3, 10});
        tbl.push_back('{5, 0, 4, 0});  tbl.push_back('{5, 0, 7, 1});
        tbl.push_back('{5, 5, 0, 0});  tbl.push_back('{5, 7, 4, 0});
        tbl.push_back('{5, 6, 3, 0});
        // phase 6: after reset mid-traffic
        tbl.push_back('{6, 0, 0, 0});  tbl.push_back('{6, 1, 1, 0});
        tbl.push_back('{6, 2, 2, 0});  tbl.push_back('{6, 3, 3, 0});
        tbl.push_back('{6, 3, 4, 0});  tbl.push_back('{6, 3, 7, 0});
        tbl.push_back('{6, 4, 0, 0});  tbl.push_back('{6, 1, 6, 0});
        tbl.push_back('{6, 2, 5, MM ? 255 : 0});

        reset = 1'b1;
        finish = 1'b0;
        clear_inputs();
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // ch0: start, 8 quiet cycles, then done&continue
        bus.ch_start[0] = 1'b1; bus.ch_ready[0] = 1'b1;
        tick();
        chk("t2_busy_set", longint'(bus.ch_busy[0]), 64'sd1);
        clear_inputs();
        repeat (8) tick();
        bus.ch_done[0] = 1'b1; bus.ch_continue[0] = 1'b1;
        tick();
        chk("t2_busy_clear", longint'(bus.ch_busy[0]), 64'sd0);
        clear_inputs();
        run_table(1);

        // ch1: done without continue, stall in the wait state
        bus.ch_start[1] = 1'b1; bus.ch_ready[1] = 1'b1;
        tick();
        clear_inputs();
        repeat (3) tick();
        bus.ch_done[1] = 1'b1;
        tick();
        bus.ch_done[1] = 1'b0;
        check_read(1, 7, 2, "t3_state_dwait");
        chk("t3_busy_dwait", longint'(bus.ch_busy[1]), 64'sd1);
        tick();
        bus.ch_continue[1] = 1'b1;
        tick();
        chk("t3_busy_clear", longint'(bus.ch_busy[1]), 64'sd0);
        clear_inputs();
        run_table(2);

        // ch2: full handshake in one cycle, then 100 iteration pulses
        bus.ch_start[2] = 1'b1; bus.ch_ready[2] = 1'b1;
        bus.ch_done[2] = 1'b1;  bus.ch_continue[2] = 1'b1;
        tick();
        chk("t4_busy_never", longint'(bus.ch_busy[2]), 64'sd0);
        clear_inputs();
        for (int i = 0; i < 100; i++) begin
            bus.ch_iter[2] = 1'b1; tick();
            bus.ch_iter[2] = 1'b0; tick();
        end
        run_table(3);

        // ch3: 300 iteration pulses saturate an 8-bit counter
        for (int i = 0; i < 300; i++) begin
            bus.ch_iter[3] = 1'b1; tick();
            bus.ch_iter[3] = 1'b0; tick();
        end
        chk("t5_any_ovf", longint'(bus.any_ovf), 64'sd1);
        run_table(4);

        // ch0 busy for 3 cycles, then frozen while events arrive
        bus.ch_start[0] = 1'b1; bus.ch_ready[0] = 1'b1;
        tick();
        clear_inputs();
        repeat (3) tick();
        finish = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.ch_iter[0] = 1'b1; bus.ch_done[0] = 1'b1; bus.ch_continue[0] = 1'b1;
            bus.ch_start[0] = 1'b1; bus.ch_ready[0] = 1'b1;
            tick();
            clear_inputs();
            tick();
        end
        chk("t6_busy_held", longint'(bus.ch_busy[0]), 64'sd1);
        run_table(5);
        finish = 1'b0;
        bus.ch_done[0] = 1'b1; bus.ch_continue[0] = 1'b1;
        tick();
        clear_inputs();

        // random traffic with occasional finish, checked against the model
        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            finish = ($urandom_range(19) == 0);
            tick();
        end
        finish = 1'b0;

        // reset for two cycles while traffic continues
        reset = 1'b1;
        rand_inputs(); tick();
        rand_inputs(); tick();
        reset = 1'b0;
        clear_inputs();
        chk("t1_any_ovf", longint'(bus.any_ovf), 64'sd0);
        chk("t1_ch_busy", longint'(bus.ch_busy), 64'sd0);
        chk("t1_rd_valid", longint'(bus.rd_valid), 64'sd0);
        run_table(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
